game_ctrl: RTL and testbench

GAME_CTRL -- requirements
Module: game_ctrl

---
 rtl/game_pkg.sv | 26 ++
 rtl/game_ctrl_if.sv | 24 ++
 rtl/game_ctrl_cycle_timer.sv | 29 ++
 rtl/game_ctrl.sv | 156 +++++++++++++++
 tb/tb_game_ctrl.sv | 295 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/game_pkg.sv
// Shared types and constants for the tile-matching game controller.
package game_pkg;

    localparam int MAX_PLAYERS = 4;
    localparam int TILE_W      = 4;
    localparam int NUM_TILES   = 16;
    localparam int PLAYER_W    = $clog2(MAX_PLAYERS);

    typedef enum logic [2:0] {
        IDLE,
        WAIT_SEL,
        FLIP,
        CHECK,
        REVEAL,
        NEXT,
        DONE
    } state_t;

    function automatic logic [PLAYER_W-1:0] next_player(
        input logic [PLAYER_W-1:0] cur,
        input logic [PLAYER_W-1:0] last
    );
        return (cur == last) ? '0 : cur + 1'b1;
    endfunction

endpackage

// File: rtl/game_ctrl_if.sv
// Flip strobe / result bus between the game controller and its datapath.
interface game_ctrl_if;
    import game_pkg::*;

    logic [TILE_W-1:0] position_data;
    logic              A;
    logic              same_result;
    logic              win;

    modport master (
        output position_data,
        output A,
        input  same_result,
        input  win
    );

    modport slave (
        input  position_data,
        input  A,
        output same_result,
        output win
    );

endinterface

// File: rtl/game_ctrl_cycle_timer.sv
// Loadable down-counter; expired is high once the count reaches zero.
module cycle_timer #(
    parameter int CYCLES = 8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic load,
    input  logic dec,
    output logic expired
);

    localparam int W = (CYCLES > 1) ? $clog2(CYCLES) : 1;
    localparam logic [W-1:0] INIT = W'(CYCLES - 1);

    logic [W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= INIT;
        end else if (dec && cnt != '0) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign expired = (cnt == '0);

endmodule

// File: rtl/game_ctrl.sv
// Turn/flip sequencer for a 2..4 player memory game.
module game_ctrl
    import game_pkg::*;
#(
    parameter int REVEAL_CYCLES = 8,
    parameter int TURN_TIMEOUT  = 1000,
    parameter int RESULT_LAT    = 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic [1:0]          N,
    input  logic                btn_flip,
    input  logic [TILE_W-1:0]   tile_sel,
    game_ctrl_if.master         dp,
    output logic                statecombo_next_turn,
    output logic [PLAYER_W-1:0] T,
    output logic [3:0]          move_cnt,
    output logic                game_over,
    output logic [PLAYER_W-1:0] winner
);

    localparam int LW = (RESULT_LAT > 1) ? $clog2(RESULT_LAT) : 1;
    localparam logic [LW-1:0] LAT_INIT = LW'(RESULT_LAT - 1);

    state_t                state;
    logic [PLAYER_W-1:0]   last_p;
    logic [NUM_TILES-1:0]  mask;
    logic [LW-1:0]         lat_cnt;

    logic flip_ok;
    logic lat_done;
    logic hit;
    logic miss;
    logic advance;
    logic turn_load;
    logic turn_exp;
    logic reveal_exp;

    assign flip_ok  = btn_flip && !mask[tile_sel];
    assign lat_done = (lat_cnt == '0);
    assign hit      = (state == CHECK) && lat_done &&
                      !dp.win && dp.same_result;
    assign miss     = (state == CHECK) && lat_done &&
                      !dp.win && !dp.same_result;

    // A press on the expiry cycle beats the timeout.
    assign advance  = ((state == WAIT_SEL) && !flip_ok && turn_exp) ||
                      ((state == REVEAL) && reveal_exp);

    assign turn_load = ((state == IDLE) && start) || hit ||
                       (state == NEXT);

    cycle_timer #(.CYCLES(TURN_TIMEOUT)) u_turn_timer (
        .clk     (clk),
        .rst_n   (rst_n),
        .load    (turn_load),
        .dec     (state == WAIT_SEL),
        .expired (turn_exp)
    );

    cycle_timer #(.CYCLES(REVEAL_CYCLES)) u_reveal_timer (
        .clk     (clk),
        .rst_n   (rst_n),
        .load    (miss),
        .dec     (state == REVEAL),
        .expired (reveal_exp)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state                <= IDLE;
            last_p               <= '0;
            mask                 <= '0;
            lat_cnt              <= '0;
            dp.A                 <= 1'b0;
            dp.position_data     <= '0;
            statecombo_next_turn <= 1'b0;
            T                    <= '0;
            move_cnt             <= '0;
            game_over            <= 1'b0;
            winner               <= '0;
        end else begin
            dp.A                 <= 1'b0;
            statecombo_next_turn <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (start) begin
                        state  <= WAIT_SEL;
                        last_p <= (N == 2'd0) ? 2'd1 : N;
                        T      <= '0;
                    end
                end
                WAIT_SEL: begin
                    if (flip_ok) begin
                        state            <= FLIP;
                        dp.A             <= 1'b1;
                        dp.position_data <= tile_sel;
                    end else if (turn_exp) begin
                        state <= NEXT;
                    end
                end
                FLIP: begin
                    state   <= CHECK;
                    lat_cnt <= LAT_INIT;
                end
                CHECK: begin
                    if (!lat_done) begin
                        lat_cnt <= lat_cnt - 1'b1;
                    end else if (dp.win) begin
                        state     <= DONE;
                        game_over <= 1'b1;
                        winner    <= T;
                    end else if (dp.same_result) begin
                        state                  <= WAIT_SEL;
                        mask[dp.position_data] <= 1'b1;
                        if (move_cnt != 4'hF) begin
                            move_cnt <= move_cnt + 4'd1;
                        end
                    end else begin
                        state <= REVEAL;
                    end
                end
                REVEAL: begin
                    if (reveal_exp) begin
                        state <= NEXT;
                    end
                end
                NEXT: begin
                    state <= WAIT_SEL;
                end
                DONE: begin
                    if (start) begin
                        state     <= IDLE;
                        game_over <= 1'b0;
                        winner    <= '0;
                        T         <= '0;
                        mask      <= '0;
                        move_cnt  <= '0;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
            // Turn bookkeeping is visible alongside the NEXT pulse.
            if (advance) begin
                statecombo_next_turn <= 1'b1;
                T                    <= next_player(T, last_p);
                mask                 <= '0;
                move_cnt             <= '0;
            end
        end
    end

endmodule

// File: tb/tb_game_ctrl.sv
// Randomized bench for game_ctrl against a game-level reference model.
module tb_game_ctrl;

    localparam int R   = 8;
    localparam int TO  = 1000;
    localparam int LAT = 1;

    localparam int PH_IDLE = 0;
    localparam int PH_WAIT = 1;
    localparam int PH_DONE = 2;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic [1:0] N = 2'd0;
    logic       btn_flip = 1'b0;
    logic [3:0] tile_sel = 4'd0;
    logic       next_turn;
    logic [1:0] T;
    logic [3:0] move_cnt;
    logic       game_over;
    logic [1:0] winner;

    game_ctrl_if dp();

    game_ctrl #(
        .REVEAL_CYCLES (R),
        .TURN_TIMEOUT  (TO),
        .RESULT_LAT    (LAT)
    ) dut (
        .clk                  (clk),
        .rst_n                (rst_n),
        .start                (start),
        .N                    (N),
        .btn_flip             (btn_flip),
        .tile_sel             (tile_sel),
        .dp                   (dp),
        .statecombo_next_turn (next_turn),
        .T                    (T),
        .move_cnt             (move_cnt),
        .game_over            (game_over),
        .winner               (winner)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Game-level model: who plays, which tiles are open, how long idle.
    int players;
    int m_t;
    int m_moves;
    int m_winner;
    int waited;
    int phase;
    bit m_over;
    bit m_rev[16];

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_tiles();
        for (int i = 0; i < 16; i++) m_rev[i] = 1'b0;
    endtask

    task automatic model_reset();
        phase    = PH_IDLE;
        m_t      = 0;
        m_moves  = 0;
        m_over   = 1'b0;
        m_winner = 0;
        waited   = 0;
        clear_tiles();
    endtask

    task automatic model_turn();
        m_t     = (m_t + 1) % players;
        m_moves = 0;
        clear_tiles();
    endtask

    task automatic check_outs(input string tag);
        chk({tag, ".T"}, T, m_t);
        chk({tag, ".moves"}, move_cnt, m_moves);
        chk({tag, ".over"}, game_over, m_over);
        chk({tag, ".winner"}, winner, m_over ? m_winner : 0);
    endtask

    task automatic do_start(input logic [1:0] n);
        N     = n;
        start = 1'b1;
        tick();
        start   = 1'b0;
        players = (n == 2'd0) ? 2 : int'(n) + 1;
        m_t     = 0;
        phase   = PH_WAIT;
        waited  = 0;
        check_outs("start");
        chk("start.pulse", next_turn, 0);
    endtask

    task automatic do_restart();
        start = 1'b1;
        tick();
        start = 1'b0;
        model_reset();
        check_outs("restart");
    endtask

    task automatic do_wait(input int n);
        for (int i = 0; i < n; i++) begin
            start = 1'($urandom);
            tick();
            waited++;
        end
        start = 1'b0;
        chk("wait.pulse", next_turn, 0);
    endtask

    task automatic do_timeout();
        int exp_lat;
        int cnt;
        exp_lat = TO - waited;
        cnt     = 0;
        for (int i = 0; i < TO + 10; i++) begin
            tick();
            cnt++;
            if (next_turn) break;
        end
        chk("timeout.lat", cnt, exp_lat);
        model_turn();
        check_outs("timeout");
        tick();
        chk("timeout.pulse_len", next_turn, 0);
        waited = 0;
    endtask

    task automatic do_flip(input logic [3:0] tile, input bit same,
                           input bit w);
        bit acc;
        int cnt;
        acc            = (phase == PH_WAIT) && !m_rev[tile];
        N              = 2'($urandom);
        tile_sel       = tile;
        btn_flip       = 1'b1;
        dp.same_result = same;
        dp.win         = w;
        tick();
        btn_flip = 1'b0;
        tile_sel = 4'($urandom);
        if (!acc) begin
            if (phase == PH_WAIT) waited++;
            chk("ign.A", dp.A, 0);
            chk("ign.pulse", next_turn, 0);
            check_outs("ign");
            dp.same_result = 1'b0;
            dp.win         = 1'b0;
            return;
        end
        chk("flip.A", dp.A, 1);
        chk("flip.pos", dp.position_data, tile);
        chk("flip.pulse", next_turn, 0);
        for (int i = 0; i <= LAT; i++) begin
            tick();
            chk("check.A", dp.A, 0);
        end
        dp.same_result = 1'($urandom);
        dp.win         = ($urandom % 4 == 0);
        if (w) begin
            m_over   = 1'b1;
            m_winner = m_t;
            phase    = PH_DONE;
            check_outs("win");
        end else if (same) begin
            m_rev[tile] = 1'b1;
            if (m_moves < 15) m_moves++;
            waited = 0;
            check_outs("match");
            chk("match.pulse", next_turn, 0);
        end else begin
            cnt = 0;
            for (int i = 0; i < R + 10; i++) begin
                tick();
                cnt++;
                if (next_turn) break;
                chk("reveal.A", dp.A, 0);
                btn_flip = 1'($urandom);
                tile_sel = 4'($urandom);
            end
            btn_flip = 1'b0;
            chk("reveal.len", cnt, R);
            model_turn();
            check_outs("next");
            tick();
            chk("next.pulse_len", next_turn, 0);
            waited = 0;
        end
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        dp.same_result = 1'b0;
        dp.win         = 1'b0;
        players        = 2;
        model_reset();
        tick();
        tick();
        chk("rst.A", dp.A, 0);
        chk("rst.pos", dp.position_data, 0);
        chk("rst.pulse", next_turn, 0);
        check_outs("rst");
        rst_n = 1'b1;

        // three players: match, repeat, three misses, timeout paths
        do_start(2'd2);
        do_flip(4'd5, 1'b1, 1'b0);
        do_flip(4'd5, 1'b1, 1'b0);
        do_flip(4'd3, 1'b0, 1'b0);
        chk("seq.T1", T, 1);
        do_flip(4'd3, 1'b0, 1'b0);
        chk("seq.T2", T, 2);
        do_flip(4'd8, 1'b0, 1'b0);
        chk("seq.T0", T, 0);
        do_timeout();
        do_wait(TO - 1);
        do_flip(4'd6, 1'b1, 1'b0);
        do_flip(4'd7, 1'b1, 1'b1);
        do_flip(4'd0, 1'b1, 1'b0);
        do_restart();

        // reset in the middle of a reveal
        do_start(2'd1);
        do_flip(4'd2, 1'b0, 1'b0);
        tile_sel       = 4'd9;
        btn_flip       = 1'b1;
        dp.same_result = 1'b0;
        dp.win         = 1'b0;
        tick();
        btn_flip = 1'b0;
        for (int i = 0; i < LAT + 4; i++) tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        model_reset();
        chk("midrst.A", dp.A, 0);
        chk("midrst.pos", dp.position_data, 0);
        chk("midrst.pulse", next_turn, 0);
        check_outs("midrst");

        // all 16 tiles matched in one turn: counter saturates
        do_start(2'd0);
        for (int t = 0; t < 16; t++) do_flip(4'(t), 1'b1, 1'b0);
        chk("sat.moves", move_cnt, 15);
        do_flip(4'd4, 1'b1, 1'b0);
        do_timeout();

        for (int k = 0; k < 400; k++) begin
            if (phase == PH_IDLE) begin
                do_start(2'($urandom));
            end else if (phase == PH_DONE) begin
                if ($urandom % 2 == 0) do_flip(4'($urandom), 1'b1, 1'b0);
                else do_restart();
            end else if (waited > TO - 20 || $urandom % 64 == 0) begin
                do_timeout();
            end else if ($urandom % 8 == 0) begin
                do_wait($urandom_range(1, 10));
            end else begin
                do_flip(4'($urandom), ($urandom % 3 != 0),
                        ($urandom % 20 == 0));
            end
        end

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
